// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DBIT data bits, optional parity, 1/2 stop bits,
// two-flop input synchroniser, false-start rejection and a valid/ready output register.
module uart_rx_cfg #(
   parameter int DBIT       = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   input  logic            rx_ready,
   output logic            rx_valid,
   output logic [DBIT-1:0] dout,
   output logic            parity_err,
   output logic            frame_err,
   output logic            overrun_err,
   output logic            busy
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int NW = $clog2(DBIT) + 1;
   localparam logic [SW-1:0] S_MID   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
   localparam logic [NW-1:0] N_STOP  = NW'(STOP_BITS - 1);
   localparam logic          PAR_ODD = 1'(PARITY_ODD);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] sh_q, sh_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;
   logic            armed_q, armed_d;
   logic            sync1, rxs;
   logic            done, done_ferr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         sh_q    <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         sh_q    <= sh_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         armed_q <= armed_d;
      end
   end

   // armed drops when a frame completes and only returns once the line has been
   // seen high, so a held-low break line yields a single frame instead of a stream.
   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      n_d       = n_q;
      sh_d      = sh_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      armed_d   = armed_q | rxs;
      done      = 1'b0;
      done_ferr = ferr_q;
      case (state_q)
         IDLE: begin
            if (!rxs && armed_q) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == S_MID) begin
                  if (!rxs) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                     perr_d  = 1'b0;
                     ferr_d  = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == S_LAST) begin
                  sh_d = {rxs, sh_q[DBIT-1:1]};
                  s_d  = '0;
                  if (n_q == N_LAST) begin
                     n_d     = '0;
                     state_d = (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (s_q == S_LAST) begin
                  perr_d  = ((^sh_q) ^ rxs) != PAR_ODD;
                  state_d = STOP;
                  s_d     = '0;
                  n_d     = '0;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_q == S_LAST) begin
                  s_d       = '0;
                  ferr_d    = ferr_q | ~rxs;
                  done_ferr = ferr_q | ~rxs;
                  if (n_q == N_STOP) begin
                     done    = 1'b1;
                     state_d = IDLE;
                     n_d     = '0;
                     armed_d = 1'b0;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A completed frame loads when the register is empty or is being drained in
   // the same cycle; otherwise the new frame is dropped and flagged as overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_valid    <= 1'b0;
         dout        <= '0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         busy        <= (state_d != IDLE);
         if (done) begin
            if (!rx_valid || rx_ready) begin
               rx_valid   <= 1'b1;
               dout       <= sh_q;
               parity_err <= perr_q;
               frame_err  <= done_ferr;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
